// File: rtl/key_fifo_if.sv
// key_fifo_if: producer/consumer PicoBlaze port bundle for the key byte FIFO.
// master = processor side (drives port_id/strobes), slave = FIFO side.
interface key_fifo_if #(
   parameter int DEPTH = 16
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [7:0]  wr_port_id;
   logic [7:0]  wr_out_port;
   logic        wr_strobe;
   logic [7:0]  rd_port_id;
   logic        rd_strobe;
   logic [7:0]  rd_in_port;
   logic        empty;
   logic        full;
   logic [AW:0] level;

   modport master (
      output wr_port_id, wr_out_port, wr_strobe, rd_port_id, rd_strobe,
      input  rd_in_port, empty, full, level
   );

   modport slave (
      input  wr_port_id, wr_out_port, wr_strobe, rd_port_id, rd_strobe,
      output rd_in_port, empty, full, level
   );
endinterface

// File: rtl/key_fifo.sv
// key_fifo: buffered mailbox carrying one-time-pad key bytes between two PicoBlaze cores.
// Define KEY_FIFO_STICKY_FLAGS_EN to add sticky overflow/underflow status bits.
module key_fifo #(
   parameter int         DEPTH       = 16,
   parameter logic [7:0] WR_PORT     = 8'h01,
   parameter logic [7:0] DATA_PORT   = 8'h80,
   parameter logic [7:0] STATUS_PORT = 8'h40
) (
   input  logic      clk,
   input  logic      reset_n,
   key_fifo_if.slave bus
);
   localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int            LW      = AW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

   logic [7:0]    mem_r [DEPTH];
   logic [AW-1:0] wp_r;
   logic [AW-1:0] rp_r;
   logic [LW-1:0] level_r;
   logic          empty_r;
   logic          full_r;
   logic [7:0]    rd_data_r;

   logic          push_req_s;
   logic          pop_req_s;
   logic          push_s;
   logic          pop_s;
   logic [LW-1:0] level_nxt_s;
   logic [7:0]    rd_mux_s;
   logic          ovf_bit_s;
   logic          udf_bit_s;

   // Decode strobes and resolve full/empty boundary cases; a pop frees room for a push when full
   always_comb begin
      push_req_s  = bus.wr_strobe && (bus.wr_port_id == WR_PORT);
      pop_req_s   = bus.rd_strobe && (bus.rd_port_id == DATA_PORT);
      pop_s       = pop_req_s && !empty_r;
      push_s      = push_req_s && (!full_r || pop_s);
      level_nxt_s = level_r;
      if (push_s && !pop_s) begin
         level_nxt_s = level_r + LW'(1);
      end else if (pop_s && !push_s) begin
         level_nxt_s = level_r - LW'(1);
      end else begin
         level_nxt_s = level_r;
      end
   end

   // Read-data mux presented to the consumer in_port, registered below
   always_comb begin
      rd_mux_s = 8'h00;
      if (bus.rd_port_id == DATA_PORT) begin
         rd_mux_s = empty_r ? 8'h00 : mem_r[rp_r];
      end else if (bus.rd_port_id == STATUS_PORT) begin
         rd_mux_s = {4'b0000, udf_bit_s, ovf_bit_s, full_r, empty_r};
      end else begin
         rd_mux_s = 8'h00;
      end
   end

   // Storage array; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wp_r] <= bus.wr_out_port;
      end
   end

   // Pointers, level, flags and registered read data
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wp_r      <= '0;
         rp_r      <= '0;
         level_r   <= '0;
         empty_r   <= 1'b1;
         full_r    <= 1'b0;
         rd_data_r <= 8'h00;
      end else begin
         if (push_s) begin
            wp_r <= wp_r + AW'(1);
         end
         if (pop_s) begin
            rp_r <= rp_r + AW'(1);
         end
         level_r   <= level_nxt_s;
         empty_r   <= (level_nxt_s == '0);
         full_r    <= (level_nxt_s == DEPTH_L);
         rd_data_r <= rd_mux_s;
      end
   end

`ifdef KEY_FIFO_STICKY_FLAGS_EN
   logic ovf_ev_s;
   logic udf_ev_s;
   logic stat_rd_s;
   logic ovf_r;
   logic udf_r;

   assign ovf_ev_s  = push_req_s && full_r && !pop_s;
   assign udf_ev_s  = pop_req_s && empty_r;
   assign stat_rd_s = bus.rd_strobe && (bus.rd_port_id == STATUS_PORT);

   // Sticky event flags; an event in the clearing cycle keeps the flag set
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovf_r <= 1'b0;
         udf_r <= 1'b0;
      end else begin
         ovf_r <= ovf_ev_s | (ovf_r & ~stat_rd_s);
         udf_r <= udf_ev_s | (udf_r & ~stat_rd_s);
      end
   end

   assign ovf_bit_s = ovf_r;
   assign udf_bit_s = udf_r;
`else
   assign ovf_bit_s = 1'b0;
   assign udf_bit_s = 1'b0;
`endif

   assign bus.rd_in_port = rd_data_r;
   assign bus.empty      = empty_r;
   assign bus.full       = full_r;
   assign bus.level      = level_r;
endmodule

// File: doc/key_fifo.md
# key_fifo

Byte FIFO between the random-generator PicoBlaze (producer of one-time-pad key bytes) and the cipher PicoBlaze (consumer). It replaces the raw write-strobe handshake between the two processors with a buffered mailbox. The producer writes key bytes through an OUTPUT port. The consumer reads key bytes and a status byte through INPUT ports, and the result is registered onto its `in_port` mux input.

## Interface
Parameters:
- `DEPTH`, 16, number of entries; power of two, 2..256
- `WR_PORT`, 8'h01, producer port_id that pushes a byte
- `DATA_PORT`, 8'h80, consumer port_id that returns and pops the head byte
- `STATUS_PORT`, 8'h40, consumer port_id that returns the status byte

Ports:
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `wr_port_id`  in  8  producer port_id
- `wr_out_port`  in  8  producer out_port (write data)
- `wr_strobe`  in  1  producer write_strobe
- `rd_port_id`  in  8  consumer port_id
- `rd_strobe`  in  1  consumer read_strobe
- `rd_in_port`  out  8  registered read data to consumer in_port mux
- `empty`  out  1  FIFO holds no entries
- `full`  out  1  FIFO holds DEPTH entries
- `level`  out  log2(DEPTH)+1  current entry count

## Operation
- Storage: DEPTH×8 register array, write pointer `wp` and read pointer `rp`, each log2(DEPTH) bits, wrapping modulo DEPTH. `level` is a separate counter.
- Push condition: `wr_strobe && wr_port_id == WR_PORT`. Byte `wr_out_port` is stored at `wp`; `wp` increments.
- Pop condition: `rd_strobe && rd_port_id == DATA_PORT`. `rp` increments.
- Read mux, registered into `rd_in_port` every cycle:
  - `rd_port_id == DATA_PORT`: the entry at `rp`, or 8'h00 when empty.
  - `rd_port_id == STATUS_PORT`: `{4'b0, underflow, overflow, full, empty}`.
  - Any other port_id: 8'h00.
- Boundary rules:
  - Push while full with no pop in the same cycle: byte discarded, pointers unchanged, overflow event.
  - Push while full with a pop in the same cycle: both accepted; `level` stays at DEPTH.
  - Pop while empty: ignored, underflow event. This applies even if a push occurs in the same cycle; the push is accepted and `level` becomes 1.
  - Push and pop while non-empty and not full: `level` unchanged; both pointers advance.
  - Pointer wrap: from DEPTH-1 to 0, with no gap or bubble.
- `empty` = (`level` == 0); `full` = (`level` == DEPTH). Both are registered, derived from the next-state `level`.
- Reset, asynchronous assert: `wp`=`rp`=0, `level`=0, `empty`=1, `full`=0, `rd_in_port`=8'h00, sticky flags=0. Array contents are not reset.
- Reset asserted mid-operation discards all contents; the first read after deassert sees empty.

## Timing
- Push at edge N: `level`, `empty` and `full` update at edge N.
- Pushed byte appears on `rd_in_port` at edge N+1, provided `rd_port_id == DATA_PORT` during cycle N+1.
- The kcpsm3 INPUT instruction holds port_id for 2 cycles and asserts read_strobe in the second. `rd_in_port` registered at the end of the first cycle is therefore stable when the consumer samples it. One-cycle registered latency is required.
- Pop at the read_strobe edge. The next head byte is presented from the following cycle.
- Throughput: 1 push and 1 pop per cycle.

## Configuration
- `KEY_FIFO_STICKY_FLAGS_EN` defined:
  - Status bit 2 (overflow) and bit 3 (underflow) are sticky; they set on the corresponding event.
  - Both clear on the edge where `rd_strobe && rd_port_id == STATUS_PORT`.
  - A new event in that same cycle wins; the flag stays set.
- Undefined: bits 2 and 3 read 0, and no flag registers are synthesized.

## Test plan
- Reset, then read STATUS_PORT → `rd_in_port`=8'h01; `empty`=1, `full`=0, `level`=0.
- Push 8'hA5, 8'h3C; read DATA_PORT twice → 8'hA5 then 8'h3C; `level` 2→1→0; `empty`=1 afterwards.
- Push 17 bytes 0x00..0x10 with DEPTH=16 → `full`=1 after 16 pushes, 0x10 dropped; with the macro, STATUS reads 8'h06 and then 8'h02 on the next read. Pop all → 0x00..0x0F in order.
- Fill to 16, then push 8'h77 and pop in the same cycle → `level` stays 16; the last popped value after draining is 8'h77. Pointers have wrapped.
- Pop on empty with a simultaneous push of 8'h5A → `level`=1, DATA_PORT reads 8'h5A; with the macro, STATUS reads 8'h08.
- Assert `reset_n`=0 asynchronously between clock edges with `level`=5 → `level`=0, `empty`=1, `rd_in_port`=8'h00 immediately, without waiting for a clock edge.
